// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - RX byte, ALU and TX byte signals of alu_cmd_sequencer
// master: the sequencer side; slave: the UART/ALU side.
interface alu_cmd_sequencer_if #(
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 16
);
  logic [7:0]               rx_p_data;
  logic                     rx_d_vld;
  logic [OPERAND_WIDTH-1:0] alu_a;
  logic [OPERAND_WIDTH-1:0] alu_b;
  logic [3:0]               alu_fun;
  logic                     alu_en;
  logic [RESULT_WIDTH-1:0]  alu_out;
  logic                     alu_out_vld;
  logic [7:0]               tx_p_data;
  logic                     tx_d_vld;
  logic                     tx_busy;
  logic                     busy;
  logic                     err;

  modport master (
    input  rx_p_data, rx_d_vld, alu_out, alu_out_vld, tx_busy,
    output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, busy, err
  );

  modport slave (
    output rx_p_data, rx_d_vld, alu_out, alu_out_vld, tx_busy,
    input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld, busy, err
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - RX command frames (CC a b f / DD f) to ALU, result back as two TX bytes
// Optional macro ALU_TIMEOUT_EN: abort ALU_RUN after TIMEOUT_CYCLES with a one-cycle ERR pulse.
module alu_cmd_sequencer #(
  parameter int OPERAND_WIDTH  = 8,
  parameter int RESULT_WIDTH   = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_cmd_sequencer_if.master  bus
);

  if (OPERAND_WIDTH != 8 || RESULT_WIDTH != 16 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("alu_cmd_sequencer: unsupported parameter set");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_ALU_RUN,
    S_TX_LO, S_TX_LO_GAP, S_TX_HI, S_TX_HI_GAP
  } state_t;

  state_t                   state_q, state_d;
  logic [OPERAND_WIDTH-1:0] a_q, b_q;
  logic [3:0]               fun_q;
  logic [RESULT_WIDTH-1:0]  result_q;
  logic                     armed_q;
  logic                     capture;
  logic                     timeout;
  logic                     err_q;

  // armed_q masks a valid seen in the very cycle ALU_EN rises
  assign capture = (state_q == S_ALU_RUN) && armed_q && bus.alu_out_vld;

`ifdef ALU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  assign timeout = (state_q == S_ALU_RUN) && !capture && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == S_ALU_RUN) ? cnt_q + 1'b1 : '0;
      err_q <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_q   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_d_vld) begin
          if (bus.rx_p_data == 8'hCC) begin
            state_d = S_GET_A;
          end else if (bus.rx_p_data == 8'hDD) begin
            state_d = S_GET_FUN;
          end
        end
      end
      S_GET_A:     if (bus.rx_d_vld) state_d = S_GET_B;
      S_GET_B:     if (bus.rx_d_vld) state_d = S_GET_FUN;
      S_GET_FUN:   if (bus.rx_d_vld) state_d = S_ALU_RUN;
      S_ALU_RUN: begin
        if (capture) begin
          state_d = S_TX_LO;
        end else if (timeout) begin
          state_d = S_IDLE;
        end
      end
      S_TX_LO:     if (!bus.tx_busy) state_d = S_TX_LO_GAP;
      S_TX_LO_GAP: state_d = S_TX_HI;
      S_TX_HI:     if (!bus.tx_busy) state_d = S_TX_HI_GAP;
      S_TX_HI_GAP: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      fun_q    <= '0;
      result_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (state_q == S_GET_A && bus.rx_d_vld) a_q <= bus.rx_p_data;
      if (state_q == S_GET_B && bus.rx_d_vld) b_q <= bus.rx_p_data;
      if (state_q == S_GET_FUN && bus.rx_d_vld) fun_q <= bus.rx_p_data[3:0];
      armed_q <= (state_q == S_ALU_RUN);
      if (capture) result_q <= bus.alu_out;
    end
  end

  always_comb begin
    bus.alu_a     = a_q;
    bus.alu_b     = b_q;
    bus.alu_fun   = fun_q;
    bus.alu_en    = (state_q == S_ALU_RUN);
    bus.tx_d_vld  = 1'b0;
    bus.tx_p_data = 8'h00;
    bus.busy      = (state_q != S_IDLE);
    bus.err       = err_q;
    if (state_q == S_TX_LO) begin
      bus.tx_d_vld  = 1'b1;
      bus.tx_p_data = result_q[7:0];
    end else if (state_q == S_TX_HI) begin
      bus.tx_d_vld  = 1'b1;
      bus.tx_p_data = result_q[15:8];
    end
  end

endmodule
